flash_burst_reader: RTL and testbench

- Parametrised successor to the single-word flash reader.
- Issues one variable-length burst read (1..MAX_BURST words) to the flash/Avalon-MM slave and honours wait_flag and per-beat read_valid.
- Buffers returned words in an internal FIFO and hands them to the consumer with a valid/ready handshake.
- Sits between the audio/sample fetch logic and the flash controller; replaces per-word reads in the playback path.

---
 rtl/flash_rd_pkg.sv | 22 ++
 rtl/flash_rd_fifo.sv | 64 ++++++
 rtl/flash_burst_reader.sv | 133 +++++++++++++
 tb/tb_flash_burst_reader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_rd_pkg.sv
// Shared types and defaults for the burst flash reader: FSM states, default
// widths and the burst-length legality check.
package flash_rd_pkg;

  localparam int DEF_ADDR_W     = 23;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MAX_BURST  = 8;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    COLLECT,
    DRAIN
  } state_t;

  function automatic logic burst_len_ok(input int unsigned len,
                                        input int unsigned max_burst);
    return (len >= 1) && (len <= max_burst);
  endfunction

endpackage

// File: rtl/flash_rd_fifo.sv
// Show-ahead return buffer: dout always presents the oldest stored word;
// push and pop may happen in the same cycle.
module flash_rd_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic [DATA_W-1:0]                  din,
  input  logic                               pop,
  output logic [DATA_W-1:0]                  dout,
  output logic                               empty,
  output logic                               full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/flash_burst_reader.sv
// Issues one variable-length burst read to an Avalon-MM flash slave and
// streams the returned words to a consumer through a valid/ready FIFO.
module flash_burst_reader
  import flash_rd_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int BCNT_W     = $clog2(MAX_BURST) + 1,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_read,
  input  logic [ADDR_W-1:0] request_addr,
  input  logic [BCNT_W-1:0] burst_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] addr_out,
  output logic [BCNT_W-1:0] burstcount,
  output logic              read,
  input  logic              wait_flag,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < MAX_BURST) begin : g_depth_check
    $error("flash_burst_reader: FIFO_DEPTH must be >= MAX_BURST");
  end

  state_t            state;
  state_t            state_next;
  logic [BCNT_W-1:0] beats_left;
  logic              legal;
  logic              beat;
  logic              last_beat;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;

  assign legal = burst_len_ok(32'(burst_len), 32'(MAX_BURST));

  // A beat in the acceptance cycle itself counts; beats in IDLE/DRAIN never do.
  assign beat      = read_valid && (beats_left != '0) &&
                     (((state == REQ) && !wait_flag) || (state == COLLECT));
  assign last_beat = beat && (beats_left == BCNT_W'(1));
  assign push      = beat && !fifo_full;
  assign data_valid = !fifo_empty;
  assign pop       = data_valid && data_ready;

  flash_rd_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (data_in),
    .pop   (pop),
    .dout  (data_out),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_read && legal) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (!wait_flag) begin
          state_next = last_beat ? DRAIN : COLLECT;
        end
      end
      COLLECT: begin
        if (last_beat) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (fifo_count == CNT_W'(1))) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    read = (state == REQ);
    busy = (state != IDLE);
    done = (state == DRAIN) && pop && (fifo_count == CNT_W'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_out   <= '0;
      burstcount <= '0;
      beats_left <= '0;
      err        <= 1'b0;
    end else begin
      err <= (state == IDLE) && start_read && !legal;
      if ((state == IDLE) && start_read && legal) begin
        addr_out   <= request_addr;
        burstcount <= burst_len;
        beats_left <= burst_len;
      end else if (beat) begin
        beats_left <= beats_left - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flash_burst_reader.sv
// Self-checking bench for flash_burst_reader: a table of burst scenarios plus
// randomized bursts, with hand-written sequences for reset and stray beats.
module tb_flash_burst_reader;

  localparam int ADDR_W      = 23;
  localparam int DATA_W      = 32;
  localparam int MAX_BURST   = 8;
  localparam int BCNT_W      = 4;
  localparam int FIFO_DEPTH  = 8;
  localparam int CYCLE_LIMIT = 400;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                len;
    int                wait_cycles;
    int                gap_max;
    bit                early;
    int                ready_mode;
    logic [DATA_W-1:0] base;
    bit                poke;
  } vec_t;

  logic              clk;
  logic              reset;
  logic              start_read;
  logic [ADDR_W-1:0] request_addr;
  logic [BCNT_W-1:0] burst_len;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] addr_out;
  logic [BCNT_W-1:0] burstcount;
  logic              read;
  logic              wait_flag;
  logic [DATA_W-1:0] data_in;
  logic              read_valid;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  flash_burst_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_BURST  (MAX_BURST),
    .BCNT_W     (BCNT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_read   (start_read),
    .request_addr (request_addr),
    .burst_len    (burst_len),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .addr_out     (addr_out),
    .burstcount   (burstcount),
    .read         (read),
    .wait_flag    (wait_flag),
    .data_in      (data_in),
    .read_valid   (read_valid),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic driveIdle();
    start_read = 1'b0;
    wait_flag  = 1'b0;
    read_valid = 1'b0;
    data_ready = 1'b0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    driveIdle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Slave and consumer model for one request; expectations come from the
  // burst rules: read lasts wait+1 cycles, words return in order one cycle
  // after their beat, done marks the final pop and busy drops right after.
  task automatic applyStimulus(input vec_t v);
    logic [DATA_W-1:0] words[$];
    int beat_cyc[$];
    int nb, pops, pushed_before, read_cycles, c, last_cyc;
    int read_bad, stable_bad, dv_bad, busy_bad, done_bad;
    bit exp_done;
    bit legal;
    legal = (v.len >= 1) && (v.len <= MAX_BURST);
    @(negedge clk);
    start_read   = 1'b1;
    request_addr = v.addr;
    burst_len    = BCNT_W'(v.len);
    wait_flag    = 1'b0;
    read_valid   = 1'b0;
    data_ready   = 1'b0;
    if (!legal) begin
      @(negedge clk);
      start_read = 1'b0;
      #1;
      checkOutput($sformatf("err pulse len=%0d", v.len), err, 1);
      checkOutput("illegal read", read, 0);
      checkOutput("illegal busy", busy, 0);
      @(negedge clk);
      #1;
      checkOutput("err one cycle", err, 0);
      checkOutput("illegal read later", read, 0);
      return;
    end
    c = v.early ? v.wait_cycles : v.wait_cycles + 1;
    for (int i = 0; i < v.len; i++) begin
      c += int'($urandom_range(0, v.gap_max));
      beat_cyc.push_back(c);
      words.push_back((v.base != 0) ? v.base + DATA_W'(i) : $urandom);
      c++;
    end
    last_cyc = beat_cyc[v.len-1];
    nb = 0; pops = 0; read_cycles = 0;
    read_bad = 0; stable_bad = 0; dv_bad = 0; busy_bad = 0; done_bad = 0;
    for (int k = 0; k < CYCLE_LIMIT && pops < v.len; k++) begin
      @(negedge clk);
      start_read   = v.poke && (k == v.wait_cycles + 1);
      request_addr = ~v.addr;
      burst_len    = BCNT_W'(2);
      wait_flag    = (k < v.wait_cycles);
      pushed_before = nb;
      if (nb < v.len && beat_cyc[nb] == k) begin
        read_valid = 1'b1;
        data_in    = words[nb];
        nb++;
      end else if (k == last_cyc + 1) begin
        read_valid = 1'b1;
        data_in    = 32'hBAD0_0000;
      end else begin
        read_valid = 1'b0;
        data_in    = $urandom;
      end
      case (v.ready_mode)
        0:       data_ready = 1'b1;
        1:       data_ready = 1'($urandom_range(0, 1));
        default: data_ready = (k > last_cyc);
      endcase
      #1;
      if (read) begin
        read_cycles++;
        if (addr_out !== v.addr || burstcount !== BCNT_W'(v.len)) stable_bad++;
      end
      if (read !== (k <= v.wait_cycles)) read_bad++;
      if (data_valid !== (pushed_before > pops)) dv_bad++;
      if (busy !== 1'b1) busy_bad++;
      exp_done = 1'b0;
      if (data_valid && data_ready) begin
        checkOutput($sformatf("word[%0d]", pops), data_out, words[pops]);
        exp_done = (pops == v.len - 1);
        pops++;
      end
      if (done !== exp_done) done_bad++;
    end
    checkOutput("words delivered", pops, v.len);
    @(negedge clk);
    driveIdle();
    #1;
    checkOutput("busy after burst", busy, 0);
    checkOutput("data_valid after burst", data_valid, 0);
    checkOutput("done after burst", done, 0);
    checkOutput("read cycles", read_cycles, v.wait_cycles + 1);
    checkOutput("read timing errors", read_bad, 0);
    checkOutput("addr/burstcount stability errors", stable_bad, 0);
    checkOutput("data_valid latency errors", dv_bad, 0);
    checkOutput("busy errors", busy_bad, 0);
    checkOutput("done errors", done_bad, 0);
    if (pops < v.len) pulseReset();
  endtask

  task automatic resetMidBurst();
    int bad;
    @(negedge clk);
    start_read   = 1'b1;
    request_addr = 23'h000123;
    burst_len    = BCNT_W'(8);
    data_ready   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start_read = 1'b0;
      wait_flag  = 1'b0;
      read_valid = (k >= 1);
      data_in    = 32'h100 + DATA_W'(k);
    end
    #1;
    checkOutput("mid-burst busy", busy, 1);
    checkOutput("mid-burst data_valid", data_valid, 1);
    @(negedge clk);
    read_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset data_valid", data_valid, 0);
    checkOutput("async reset read", read, 0);
    checkOutput("async reset addr_out", addr_out, 0);
    checkOutput("async reset burstcount", burstcount, 0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      read_valid = 1'b1;
      data_in    = 32'h200 + DATA_W'(k);
      data_ready = 1'b1;
      #1;
      if (data_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checkOutput("beats after reset ignored", bad, 0);
    @(negedge clk);
    driveIdle();
  endtask

  vec_t vecs[8];

  initial begin
    int bad;
    vec_t rv;
    vecs[0] = '{addr: 23'h000005, len: 1, wait_cycles: 0, gap_max: 0, early: 0,
                ready_mode: 0, base: 32'hDEADBEEF, poke: 0};
    vecs[1] = '{addr: 23'h012340, len: 8, wait_cycles: 3, gap_max: 2, early: 0,
                ready_mode: 0, base: 32'h10, poke: 0};
    vecs[2] = '{addr: 23'h7FFFF8, len: 8, wait_cycles: 1, gap_max: 1, early: 0,
                ready_mode: 2, base: 32'h0, poke: 0};
    vecs[3] = '{addr: 23'h000100, len: 4, wait_cycles: 0, gap_max: 0, early: 0,
                ready_mode: 0, base: 32'hA0, poke: 0};
    vecs[4] = '{addr: 23'h000200, len: 0, wait_cycles: 0, gap_max: 0, early: 0,
                ready_mode: 0, base: 32'h0, poke: 0};
    vecs[5] = '{addr: 23'h000300, len: 9, wait_cycles: 0, gap_max: 0, early: 0,
                ready_mode: 0, base: 32'h0, poke: 0};
    vecs[6] = '{addr: 23'h055555, len: 5, wait_cycles: 1, gap_max: 3, early: 1,
                ready_mode: 1, base: 32'h0, poke: 1};
    vecs[7] = '{addr: 23'h000400, len: 15, wait_cycles: 0, gap_max: 0, early: 0,
                ready_mode: 0, base: 32'h0, poke: 0};

    reset        = 1'b1;
    request_addr = '0;
    burst_len    = '0;
    data_in      = '0;
    driveIdle();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset read", read, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset data_valid", data_valid, 0);
    checkOutput("reset addr_out", addr_out, 0);
    checkOutput("reset burstcount", burstcount, 0);
    @(negedge clk);
    reset = 1'b0;

    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      read_valid = 1'b1;
      data_in    = $urandom;
      #1;
      if (data_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    @(negedge clk);
    driveIdle();
    #1;
    checkOutput("stray read_valid in IDLE", bad, 0);
    checkOutput("stray leaves FIFO empty", data_valid, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end

    resetMidBurst();
    rv = '{addr: 23'h000ABC, len: 2, wait_cycles: 0, gap_max: 1, early: 0,
           ready_mode: 0, base: 32'h0, poke: 0};
    applyStimulus(rv);

    for (int i = 0; i < 12; i++) begin
      rv.addr        = ADDR_W'($urandom);
      rv.len         = int'($urandom_range(0, 10));
      rv.wait_cycles = int'($urandom_range(0, 4));
      rv.gap_max     = int'($urandom_range(0, 3));
      rv.early       = 1'($urandom_range(0, 1));
      rv.ready_mode  = int'($urandom_range(0, 2));
      rv.base        = '0;
      rv.poke        = 1'($urandom_range(0, 1));
      applyStimulus(rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
